// File: rtl/led_blink_ctrl.sv
// Blink sequencer for the LED pattern decoder select line.
// Runs N on/off cycles (N=0: forever) with durations latched at start.
module led_blink_ctrl #(
  parameter int DIV_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] on_ticks,
  input  logic [DIV_W-1:0] off_ticks,
  input  logic [CNT_W-1:0] count,
  output logic             sel,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  typedef enum logic [1:0] {IDLE, ON, OFF, DONE} state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] phase, phase_nxt;
  logic [DIV_W-1:0] on_l, on_nxt, off_l, off_nxt;
  logic [CNT_W-1:0] cnt_l, cnt_nxt, rem_nxt;
  logic [DIV_W-1:0] on_eff, off_eff;
  logic             phase_end;

  // Zero durations collapse to a single cycle so the down-counter never wraps.
  assign on_eff    = (on_ticks  == '0) ? DIV_W'(1) : on_ticks;
  assign off_eff   = (off_ticks == '0) ? DIV_W'(1) : off_ticks;
  assign phase_end = (phase == DIV_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= '0;
      on_l      <= '0;
      off_l     <= '0;
      cnt_l     <= '0;
      remaining <= '0;
      sel       <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      on_l      <= on_nxt;
      off_l     <= off_nxt;
      cnt_l     <= cnt_nxt;
      remaining <= rem_nxt;
      sel       <= (state_nxt != ON);
      busy      <= (state_nxt == ON) || (state_nxt == OFF);
      done      <= (state_nxt == DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    on_nxt    = on_l;
    off_nxt   = off_l;
    cnt_nxt   = cnt_l;
    rem_nxt   = remaining;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          on_nxt    = on_eff;
          off_nxt   = off_eff;
          cnt_nxt   = count;
          rem_nxt   = count;
          phase_nxt = on_eff;
          state_nxt = ON;
        end
      end
      ON: begin
        if (phase_end) begin
          phase_nxt = off_l;
          state_nxt = OFF;
        end else begin
          phase_nxt = phase - DIV_W'(1);
        end
      end
      OFF: begin
        if (phase_end) begin
          if (cnt_l == '0) begin
            phase_nxt = on_l;
            state_nxt = ON;
          end else if (remaining == CNT_W'(1)) begin
            rem_nxt   = '0;
            phase_nxt = '0;
            state_nxt = DONE;
          end else begin
            rem_nxt   = remaining - CNT_W'(1);
            phase_nxt = on_l;
            state_nxt = ON;
          end
        end else begin
          phase_nxt = phase - DIV_W'(1);
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Abort wins over everything outside IDLE.
    if (abort && state != IDLE) begin
      state_nxt = IDLE;
      rem_nxt   = '0;
      phase_nxt = '0;
    end
  end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Scoreboard bench for led_blink_ctrl: per-cycle expected outputs are
// queued when a sequence is launched and popped each cycle after the edge.
module tb_led_blink_ctrl;

  localparam int DIV_W = 24;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [DIV_W-1:0] on_ticks = '0;
  logic [DIV_W-1:0] off_ticks = '0;
  logic [CNT_W-1:0] count = '0;
  logic             sel, busy, done;
  logic [CNT_W-1:0] remaining;

  led_blink_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .on_ticks(on_ticks), .off_ticks(off_ticks), .count(count),
    .sel(sel), .busy(busy), .done(done), .remaining(remaining)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             sel;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] rem;
  } exp_t;

  typedef struct {
    int    cnt;
    int    on;
    int    off;
    int    restart;  // cycle index at which a stray start is pulsed (0 = none)
    string name;
  } vec_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic push(input logic s, input logic b, input logic d, input int r);
    exp_t e;
    e.sel = s; e.busy = b; e.done = d; e.rem = CNT_W'(r);
    exp_q.push_back(e);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic check_pop(input string name, input int cyc);
    exp_t e, a;
    e = exp_q.pop_front();
    a = '{sel: sel, busy: busy, done: done, rem: remaining};
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got sel=%b busy=%b done=%b rem=%0d, want sel=%b busy=%b done=%b rem=%0d",
               name, cyc, a.sel, a.busy, a.done, a.rem, e.sel, e.busy, e.done, e.rem);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int c, input int on, input int off);
    on_ticks  = DIV_W'(on);
    off_ticks = DIV_W'(off);
    count     = CNT_W'(c);
    start     = 1'b1;
    tick();
    start     = 1'b0;
    // Scramble inputs: the sequence must keep its latched values.
    on_ticks  = 7;
    off_ticks = 9;
    count     = 4;
  endtask

  task automatic push_finite(input int c, input int on, input int off);
    int on_e, off_e;
    on_e  = (on == 0) ? 1 : on;
    off_e = (off == 0) ? 1 : off;
    for (int b = 0; b < c; b++) begin
      for (int i = 0; i < on_e; i++)  push(1'b0, 1'b1, 1'b0, c - b);
      for (int i = 0; i < off_e; i++) push(1'b1, 1'b1, 1'b0, c - b);
    end
    push(1'b1, 1'b0, 1'b1, 0);
    push_idle(2);
  endtask

  task automatic run_finite(input vec_t v);
    int cyc;
    launch(v.cnt, v.on, v.off);
    push_finite(v.cnt, v.on, v.off);
    cyc = 0;
    while (exp_q.size() != 0) begin
      check_pop(v.name, cyc);
      if (v.restart != 0 && cyc == v.restart) begin
        start = 1'b1;
        count = 1;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{cnt: 3, on: 4, off: 2, restart: 0,  name: "fin_3_4_2"};
    tbl[1] = '{cnt: 2, on: 0, off: 0, restart: 0,  name: "zero_dur"};
    tbl[2] = '{cnt: 1, on: 1, off: 1, restart: 0,  name: "single_1_1"};
    tbl[3] = '{cnt: 5, on: 3, off: 3, restart: 10, name: "restart_ign"};
    tbl[4] = '{cnt: 2, on: 3, off: 1, restart: 0,  name: "fin_2_3_1"};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    push_idle(1);
    check_pop("reset", 0);
    rst = 1'b0;
    tick();
    push_idle(1);
    check_pop("post_reset", 0);

    foreach (tbl[i]) run_finite(tbl[i]);

    // Continuous blinking, then abort
    launch(0, 2, 2);
    for (int i = 0; i < 120; i++) push(((i % 4) >= 2), 1'b1, 1'b0, 0);
    for (int i = 0; i < 120; i++) begin
      check_pop("continuous", i);
      if (i != 119) tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    push_idle(3);
    for (int i = 0; i < 3; i++) begin
      check_pop("abort", i);
      tick();
    end

    // Async reset mid-ON
    launch(3, 4, 2);
    push(1'b0, 1'b1, 1'b0, 3);
    push(1'b0, 1'b1, 1'b0, 3);
    check_pop("pre_rst", 0);
    tick();
    check_pop("pre_rst", 1);
    #3;
    rst = 1'b1;
    #1;
    push_idle(1);
    check_pop("async_rst", 0);
    tick();
    rst = 1'b0;
    tick();
    run_finite(tbl[0]);

    // start and abort together in IDLE
    on_ticks = 2; off_ticks = 2; count = 2;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    push_idle(3);
    for (int i = 0; i < 3; i++) begin
      check_pop("start_abort", i);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: sim time exceeded, want finish");
    $fatal(1, "timeout");
  end

endmodule
